// File: rtl/di_defs.sv
// Shared register-map definitions for the host-interface read FIFO endpoint.
package di_defs;

  localparam logic [15:0] DI_REG_DATA   = 16'd0;
  localparam logic [15:0] DI_REG_STATUS = 16'd1;

  // Status word layout: {overflow, underflow, fill[13:0]}
  localparam int DI_STAT_OVF_BIT = 15;
  localparam int DI_STAT_UNF_BIT = 14;
  localparam int DI_STAT_FILL_W  = 14;

endpackage

// File: rtl/di_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module di_fifo_mem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              if_clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge if_clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/di_read_fifo.sv
// First-word-fall-through read FIFO endpoint on the host data interface.
// Define DI_FIFO_STATUS_EN to build in the sticky-flag status register.
module di_read_fifo
  import di_defs::*;
#(
  parameter logic [15:0] EP_ADDR    = 16'h0001,
  parameter int          DEPTH_LOG2 = 9
) (
  input  logic                  if_clock,
  input  logic                  resetb,
  input  logic [15:0]           diEpAddr,
  input  logic [15:0]           diRegAddr,
  input  logic                  diRead,
  input  logic                  diReset,
  output logic [15:0]           diRegDataOut,
  output logic                  rd_ready,
  input  logic [15:0]           src_data,
  input  logic                  src_valid,
  output logic                  src_full,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PW-1:0] wptr, rptr;
  logic          full, empty;
  logic          sel, data_sel, pop, push;
  logic [15:0]   head;

  assign fill     = wptr - rptr;
  assign full     = (fill == DEPTH);
  assign empty    = (fill == '0);
  assign src_full = full;

  assign sel      = (diEpAddr == EP_ADDR);
  assign data_sel = sel && (diRegAddr == DI_REG_DATA);
  assign pop      = data_sel && diRead && !empty;
  // A pop frees a slot in the same edge, so a full FIFO still accepts the push
  assign push     = src_valid && (!full || pop);

  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      wptr <= '0;
      rptr <= '0;
    end else if (diReset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  di_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (16)
  ) u_mem (
    .if_clock (if_clock),
    .we       (push && !diReset),
    .waddr    (wptr[DEPTH_LOG2-1:0]),
    .wdata    (src_data),
    .raddr    (rptr[DEPTH_LOG2-1:0]),
    .rdata    (head)
  );

`ifdef DI_FIFO_STATUS_EN
  logic        overflow, underflow;
  logic        stat_sel, stat_clr, ovf_evt, unf_evt;
  logic [15:0] status_word;

  assign stat_sel = sel && (diRegAddr == DI_REG_STATUS);
  assign stat_clr = stat_sel && diRead;
  assign ovf_evt  = src_valid && full && !pop;
  assign unf_evt  = data_sel && diRead && empty;

  // A fresh event in the same cycle as a status read survives the clear
  always_ff @(posedge if_clock or negedge resetb) begin
    if (!resetb) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (diReset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  && !stat_clr) || ovf_evt;
      underflow <= (underflow && !stat_clr) || unf_evt;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[DI_STAT_OVF_BIT] = overflow;
    status_word[DI_STAT_UNF_BIT] = underflow;
    status_word[DI_STAT_FILL_W-1:0] = DI_STAT_FILL_W'(fill);
  end
`endif

  always_comb begin
    diRegDataOut = '0;
    rd_ready     = 1'b0;
    if (resetb && data_sel) begin
      rd_ready = (fill > PW'(diRead));
      if (!empty) diRegDataOut = head;
    end
`ifdef DI_FIFO_STATUS_EN
    else if (resetb && stat_sel) begin
      rd_ready     = 1'b1;
      diRegDataOut = status_word;
    end
`endif
  end

endmodule

// File: tb/tb_di_read_fifo.sv
// Directed self-checking bench for di_read_fifo (DEPTH_LOG2 = 2).
// Status checks are compiled in when DI_FIFO_STATUS_EN is defined.
module tb_di_read_fifo;

  localparam logic [15:0] EP = 16'h0001;

  logic        if_clock;
  logic        resetb;
  logic [15:0] diEpAddr;
  logic [15:0] diRegAddr;
  logic        diRead;
  logic        diReset;
  logic [15:0] diRegDataOut;
  logic        rd_ready;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_full;
  logic [2:0]  fill;

  int tests_run;
  int tests_failed;

  di_read_fifo #(.EP_ADDR(EP), .DEPTH_LOG2(2)) dut (
    .if_clock     (if_clock),
    .resetb       (resetb),
    .diEpAddr     (diEpAddr),
    .diRegAddr    (diRegAddr),
    .diRead       (diRead),
    .diReset      (diReset),
    .diRegDataOut (diRegDataOut),
    .rd_ready     (rd_ready),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_full     (src_full),
    .fill         (fill)
  );

  initial if_clock = 1'b0;
  always #5 if_clock = ~if_clock;

  task automatic push_word(input logic [15:0] w);
    @(negedge if_clock);
    src_valid = 1'b1;
    src_data  = w;
    @(negedge if_clock);
    src_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetb = 1'b0; diEpAddr = EP; diRegAddr = 16'd0; diRead = 1'b0;
    diReset = 1'b0; src_data = 16'h0; src_valid = 1'b0;
    #12;
    tests_run++;
    if (fill !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_fill got %0d want 0", fill); end
    tests_run++;
    if (diRegDataOut !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h want 0000", diRegDataOut); end
    tests_run++;
    if (rd_ready !== 1'b0 || src_full !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_flags got rdy=%b full=%b want 0 0", rd_ready, src_full);
    end
    @(negedge if_clock);
    resetb = 1'b1;
  endtask

  task automatic test_fwft_read();
    logic [15:0] words [3];
    logic        rdy   [3];
    words = '{16'hA1A1, 16'hA2A2, 16'hA3A3};
    rdy   = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) push_word(words[i]);
    tests_run++;
    if (fill !== 3'd3) begin tests_failed++; $display("[TB] FAIL fwft_fill_after_push got %0d want 3", fill); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge if_clock);
      diRead = 1'b1;
      #1;
      tests_run++;
      if (diRegDataOut !== words[i] || rd_ready !== rdy[i]) begin
        tests_failed++;
        $display("[TB] FAIL fwft_read%0d got %h rdy=%b want %h rdy=%b", i, diRegDataOut, rd_ready, words[i], rdy[i]);
      end
    end
    @(negedge if_clock);
    diRead = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd0) begin tests_failed++; $display("[TB] FAIL fwft_fill_end got %0d want 0", fill); end
  endtask

  task automatic test_underflow();
    push_word(16'h5A5A);
    diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h5A5A || rd_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unf_first got %h rdy=%b want 5a5a rdy=0", diRegDataOut, rd_ready);
    end
    @(negedge if_clock);
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h0 || rd_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unf_second got %h rdy=%b want 0000 rdy=0", diRegDataOut, rd_ready);
    end
    @(negedge if_clock);
    diRead = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd0) begin tests_failed++; $display("[TB] FAIL unf_fill got %0d want 0", fill); end
`ifdef DI_FIFO_STATUS_EN
    diRegAddr = 16'd1; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h4000) begin tests_failed++; $display("[TB] FAIL unf_status got %h want 4000", diRegDataOut); end
    @(negedge if_clock);
    diRegAddr = 16'd0; diRead = 1'b0;
`endif
  endtask

  task automatic test_full();
    logic [15:0] b     [5];
    logic [15:0] drain [4];
    b     = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004};
    drain = '{16'hB001, 16'hB002, 16'hB003, 16'hC000};
    for (int i = 0; i < 5; i++) begin
      @(negedge if_clock);
      src_valid = 1'b1; src_data = b[i];
      #1;
      tests_run++;
      if (src_full !== (i == 4)) begin
        tests_failed++; $display("[TB] FAIL full_flag%0d got %b want %b", i, src_full, (i == 4));
      end
    end
    @(negedge if_clock);
    src_valid = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd4) begin tests_failed++; $display("[TB] FAIL full_fill got %0d want 4", fill); end
`ifdef DI_FIFO_STATUS_EN
    diRegAddr = 16'd1; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h8004 || rd_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL status_ovf got %h rdy=%b want 8004 rdy=1", diRegDataOut, rd_ready);
    end
    @(negedge if_clock);
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h0004) begin tests_failed++; $display("[TB] FAIL status_cleared got %h want 0004", diRegDataOut); end
`else
    diRegAddr = 16'd1; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h0 || rd_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unused_addr got %h rdy=%b want 0000 rdy=0", diRegDataOut, rd_ready);
    end
`endif
    @(negedge if_clock);
    diRegAddr = 16'd0; diRead = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd4) begin tests_failed++; $display("[TB] FAIL status_no_pop got %0d want 4", fill); end
    @(negedge if_clock);
    src_valid = 1'b1; src_data = 16'hC000; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'hB000) begin tests_failed++; $display("[TB] FAIL pushpop_head got %h want b000", diRegDataOut); end
    @(negedge if_clock);
    src_valid = 1'b0; diRead = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd4) begin tests_failed++; $display("[TB] FAIL pushpop_fill got %0d want 4", fill); end
    for (int i = 0; i < 4; i++) begin
      @(negedge if_clock);
      diRead = 1'b1;
      #1;
      tests_run++;
      if (diRegDataOut !== drain[i]) begin
        tests_failed++; $display("[TB] FAIL drain%0d got %h want %h", i, diRegDataOut, drain[i]);
      end
    end
    @(negedge if_clock);
    diRead = 1'b0;
`ifdef DI_FIFO_STATUS_EN
    diRegAddr = 16'd1; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h0000) begin tests_failed++; $display("[TB] FAIL pushpop_no_ovf got %h want 0000", diRegDataOut); end
    @(negedge if_clock);
    diRegAddr = 16'd0; diRead = 1'b0;
`endif
  endtask

  task automatic test_unselected();
    push_word(16'hD000);
    push_word(16'hD001);
    diEpAddr = EP + 16'd1; diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'h0 || rd_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL unsel_out got %h rdy=%b want 0000 rdy=0", diRegDataOut, rd_ready);
    end
    @(negedge if_clock);
    diRead = 1'b0; diEpAddr = EP;
    #1;
    tests_run++;
    if (fill !== 3'd2 || diRegDataOut !== 16'hD000) begin
      tests_failed++; $display("[TB] FAIL unsel_kept got fill=%0d %h want fill=2 d000", fill, diRegDataOut);
    end
  endtask

  task automatic test_reset_flush();
    push_word(16'hD002);
    diRead = 1'b1;
    #1;
    tests_run++;
    if (diRegDataOut !== 16'hD000 || fill !== 3'd3) begin
      tests_failed++; $display("[TB] FAIL burst_head got %h fill=%0d want d000 fill=3", diRegDataOut, fill);
    end
    #2;
    resetb = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd0 || rd_ready !== 1'b0 || diRegDataOut !== 16'h0 || src_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got fill=%0d rdy=%b out=%h full=%b want 0 0 0000 0", fill, rd_ready, diRegDataOut, src_full);
    end
    @(negedge if_clock);
    diRead = 1'b0; resetb = 1'b1;
    src_valid = 1'b1; src_data = 16'hE000;
    @(negedge if_clock);
    src_valid = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd1 || diRegDataOut !== 16'hE000) begin
      tests_failed++; $display("[TB] FAIL first_push got fill=%0d %h want fill=1 e000", fill, diRegDataOut);
    end
    push_word(16'hE001);
    push_word(16'hE002);
    diReset = 1'b1; src_valid = 1'b1; src_data = 16'hE003;
    @(negedge if_clock);
    diReset = 1'b0; src_valid = 1'b0;
    #1;
    tests_run++;
    if (fill !== 3'd0 || rd_ready !== 1'b0 || diRegDataOut !== 16'h0) begin
      tests_failed++; $display("[TB] FAIL flush got fill=%0d rdy=%b out=%h want 0 0 0000", fill, rd_ready, diRegDataOut);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fwft_read();
    test_underflow();
    test_full();
    test_unselected();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
